// File: rtl/bcd_digit_loader_if.sv
// Handshake/bus bundle between a digit source (master) and bcd_digit_loader (slave).
// Both handshakes: a transfer happens on a rising edge where valid and ready are both 1.
interface bcd_digit_loader_if;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        digit_ready;
  logic        enter;
  logic        clear;
  logic [15:0] bcd_word;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  digit_count;
  logic        digit_err;
  logic        fsm_state;   // debug: 0 = COLLECT, 1 = FULL

  modport master (
    output digit, digit_valid, enter, clear, word_ready,
    input  digit_ready, bcd_word, word_valid, digit_count, digit_err, fsm_state
  );

  modport slave (
    input  digit, digit_valid, enter, clear, word_ready,
    output digit_ready, bcd_word, word_valid, digit_count, digit_err, fsm_state
  );
endinterface

// File: rtl/bcd_digit_loader.sv
// Collects up to four BCD digits MSD-first into a zero-padded 16-bit word and
// holds it under valid/ready until the downstream divisibility checker takes it.
module bcd_digit_loader (
  input  logic                clk,
  input  logic                rst,
  bcd_digit_loader_if.slave   bus
);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [2:0]  count_q, count_d;
  logic        err_q, err_d;
  logic        accept;

  assign accept = bus.digit_valid && (state_q == COLLECT);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (bus.clear) begin
      state_d = COLLECT;
      word_d  = 16'h0000;
      count_d = 3'd0;
    end else if (state_q == FULL) begin
      if (bus.word_ready) begin
        state_d = COLLECT;
        word_d  = 16'h0000;
        count_d = 3'd0;
      end
    end else if (accept) begin
      if (bus.digit <= 4'd9) begin
        word_d  = {word_q[11:0], bus.digit};
        count_d = count_q + 3'd1;
        if (count_d == 3'd4 || bus.enter) state_d = FULL;
      end else begin
        // Rejected code is consumed by the handshake but never stored.
        err_d = 1'b1;
        if (bus.enter && count_q != 3'd0) state_d = FULL;
      end
    end else if (bus.enter && count_q != 3'd0) begin
      state_d = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      word_q  <= 16'h0000;
      count_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.digit_ready = (state_q == COLLECT);
  assign bus.word_valid  = (state_q == FULL);
  assign bus.bcd_word    = word_q;
  assign bus.digit_count = count_q;
  assign bus.digit_err   = err_q;
  assign bus.fsm_state   = state_q;

endmodule

// File: doc/bcd_digit_loader.md
# bcd_digit_loader

Serial BCD digit collector that sits directly upstream of the 4-digit divisibility checker (mod-3 / mod-11 over a 16-bit packed BCD word). It accepts one decimal digit per handshake, most-significant digit first, and rejects non-decimal codes. It packs up to four digits into a zero-padded 16-bit BCD word. It holds that word stable under a valid/ready handshake until the downstream stage takes it.

## Interface

Parameters:
- none (fixed 4 digits × 4 bits; checker input is fixed at 16 bits)

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- digit  input  4  incoming BCD digit code
- digit_valid  input  1  digit is presented this cycle
- digit_ready  output  1  loader can accept a digit this cycle
- enter  input  1  finish word early with the digits collected so far
- clear  input  1  discard partial or held word
- bcd_word  output  16  packed BCD; [15:12] most significant digit, [3:0] least significant digit
- word_valid  output  1  bcd_word is complete and stable
- word_ready  input  1  downstream accepts bcd_word
- digit_count  output  3  digits collected so far (0..4)
- digit_err  output  1  one-cycle pulse: last presented digit was >9 and was dropped

## Operation

- Two states: COLLECT, FULL. Reset state is COLLECT.
- digit_ready = 1 in COLLECT, 0 in FULL. It is decoded from state, not registered separately.
- Accept = digit_valid & digit_ready.
- Accept with digit ≤ 9:
  - bcd_word ← {bcd_word[11:0], digit}
  - digit_count ← digit_count+1
  - If the new count is 4, go to FULL.
- Accept with digit ≥ 10 (A–F):
  - The handshake completes, so the digit is consumed.
  - bcd_word and digit_count are unchanged.
  - digit_err = 1 for the next cycle only.
- enter in COLLECT:
  - With digit_count ≥ 1: go to FULL. Upper digits stay 0, e.g. digits 4,2 give 16'h0042.
  - With digit_count = 0: ignored.
- enter in the same cycle as a valid digit accept: the digit is shifted in first, then the block goes to FULL including that digit.
- enter in the same cycle as an invalid digit accept: the digit is dropped. enter is honoured only if digit_count ≥ 1.
- In FULL:
  - word_valid = 1.
  - bcd_word and digit_count are frozen.
  - digit and enter are ignored.
- word_ready in FULL:
  - bcd_word ← 0, digit_count ← 0, go to COLLECT.
  - word_valid is 0 on the next cycle.
- word_ready in COLLECT has no effect.
- clear, in any state:
  - bcd_word ← 0, digit_count ← 0, go to COLLECT, digit_err ← 0.
  - Overrides a simultaneous digit accept, enter, or word_ready.
- Priority: rst > clear > word_ready (FULL) > digit accept > enter.
- digit_count never exceeds 4; bcd_word never contains a nibble > 9.

## Timing

- Reset values after rst in the cycle before an edge:
  - bcd_word = 16'h0000
  - word_valid = 0
  - digit_count = 0
  - digit_err = 0
  - state COLLECT, so digit_ready = 1 combinationally
- rst asserted mid-word or in FULL gives the same values on the next edge; the held word is lost with no handshake.
- All outputs are registered except digit_ready, which is a pure state decode.
- A digit accepted on edge N is visible in bcd_word[3:0] after edge N.
- The 4th valid accept on edge N gives word_valid = 1 and digit_ready = 0 after edge N.
- enter sampled on edge N with count ≥ 1 gives word_valid = 1 after edge N.
- word_valid & word_ready on edge N:
  - word_valid = 0 and digit_ready = 1 after edge N.
  - The next digit can be accepted on edge N+1.
- Minimum word period is 5 cycles: 4 accepts plus 1 transfer.
- digit_err is high for exactly one cycle per rejected digit. Back-to-back invalid digits keep it high continuously.
- bcd_word must not change while word_valid = 1; downstream may sample it on any cycle while valid.

## Test plan

- Reset, then digits 1,2,3,4 on 4 consecutive cycles with word_ready = 0 -> bcd_word = 16'h1234 and word_valid = 1 after the 4th edge. digit_ready = 0 and bcd_word is held for 10 cycles. word_ready = 1 gives word_valid = 0 and bcd_word = 0 on the next cycle.
- Digits 9,C,9 then enter -> digit_err pulses once after C. bcd_word = 16'h0099 with word_valid = 1 and digit_count = 2.
- enter with no digits collected -> no state change and word_valid stays 0. Next, digit 7 and enter in the same cycle -> bcd_word = 16'h0007, word_valid = 1.
- Digits 5,6, then clear together with digit 8 -> bcd_word = 0 and digit_count = 0. Digit 8 is not loaded. Then 3,0,0,3 -> 16'h3003.
- In FULL with word_ready = 0, drive digit_valid = 1 with digit 5 for 3 cycles -> no change to bcd_word, digit_ready = 0 throughout. Assert rst -> all outputs return to reset values on the next edge.
- Random stream of 1000 digits 0–F with random word_ready/clear -> a scoreboard matches every transferred bcd_word. Each transferred word, fed into the mod-3/mod-11 checker, agrees with a reference model of (value mod 3 == 0) and (value mod 11 == 0).
